// File: rtl/alu_cond_resolve.sv
// Resolves set-condition and zero-compare branch results from the ALU into a
// set value / taken bit, queued in a 2-entry valid/ready buffer.
module alu_cond_resolve #(
   parameter int DEPTH = 2,
   parameter int TAGW  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_cond,
   input  logic [15:0]     in_res,
   input  logic            in_z,
   input  logic            in_ofl,
   input  logic            in_co,
   input  logic [15:0]     in_a,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [15:0]     out_set,
   output logic            out_taken,
   output logic            out_is_br,
   output logic [TAGW-1:0] out_tag,
   output logic [15:0]     taken_cnt
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   typedef struct packed {
      logic            set;
      logic            taken;
      logic            is_br;
      logic [TAGW-1:0] tag;
   } entry_t;

   function automatic entry_t resolve(
      input logic [2:0]        cond,
      input logic signed [15:0] res,
      input logic              z,
      input logic              ofl,
      input logic              co,
      input logic signed [15:0] a,
      input logic [TAGW-1:0]   tag
   );
      entry_t e;
      logic   slt;
      slt     = res[15] ^ ofl;
      e.set   = 1'b0;
      e.taken = 1'b0;
      e.is_br = cond[2];
      e.tag   = tag;
      case (cond)
         3'd0:    e.set   = z;
         3'd1:    e.set   = slt;
         3'd2:    e.set   = slt | z;
         3'd3:    e.set   = co;
         3'd4:    e.taken = (a == 16'sd0);
         3'd5:    e.taken = (a != 16'sd0);
         3'd6:    e.taken = (a < 16'sd0);
         default: e.taken = (a >= 16'sd0);
      endcase
      return e;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic signed [15:0] res_p0;
   logic signed [15:0] a_p0;
   entry_t             ent_p0;
   logic               push;
   logic               pop;
   logic [1:0]         count;
   entry_t             head_q;
   entry_t             tail_q;

   // Resolve stage: flags are turned into the entry before it is stored
   assign res_p0 = in_res;
   assign a_p0   = in_a;
   assign ent_p0 = resolve(in_cond, res_p0, in_z, in_ofl, in_co, a_p0, in_tag);

   assign in_ready  = (count < FULL);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_set   = {15'd0, head_q.set};
   assign out_taken = head_q.taken;
   assign out_is_br = head_q.is_br;
   assign out_tag   = head_q.tag;

   // Buffer stage: head entry drives the outputs straight from flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= 2'd0;
         head_q    <= '0;
         taken_cnt <= 16'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         if (pop && head_q.is_br && head_q.taken)
            taken_cnt <= sat_inc(taken_cnt);
         case ({push, pop})
            2'b10: count <= count + 2'd1;
            2'b01: count <= count - 2'd1;
            default: count <= count;
         endcase
         if (pop && count == 2'd2)
            head_q <= tail_q;
         else if (push && (count == 2'd0 || pop))
            head_q <= ent_p0;
      end
   end

   // Second slot only fills when the head is occupied and not leaving
   always_ff @(posedge clk) begin
      if (push && count == 2'd1 && !pop && !flush)
         tail_q <= ent_p0;
   end

endmodule

// File: tb/tb_alu_cond_resolve.sv
// Randomized and directed bench for alu_cond_resolve with a queue-based reference model.
module tb_alu_cond_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_cond;
   logic [15:0] in_res;
   logic        in_z;
   logic        in_ofl;
   logic        in_co;
   logic [15:0] in_a;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_set;
   logic        out_taken;
   logic        out_is_br;
   logic [3:0]  out_tag;
   logic [15:0] taken_cnt;

   alu_cond_resolve #(.DEPTH(2), .TAGW(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
      .in_res(in_res), .in_z(in_z), .in_ofl(in_ofl), .in_co(in_co),
      .in_a(in_a), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_set(out_set),
      .out_taken(out_taken), .out_is_br(out_is_br), .out_tag(out_tag),
      .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] set;
      logic        taken;
      logic        is_br;
      logic [3:0]  tag;
   } ent_t;

   ent_t        q[$];
   logic [15:0] mcnt;
   logic [15:0] drv_set;
   logic        drv_taken;
   int          checks = 0;
   int          fails = 0;
   bit          chk_en = 1'b0;
   int          m_sz;
   bit          m_push;
   bit          m_pop;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive ALU operands; flags come from real arithmetic, expectations from signed compares
   task automatic drive(input bit v, input logic [2:0] cond, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag);
      logic [16:0] sum;
      logic [15:0] diff;
      sum  = {1'b0, a} + {1'b0, b};
      diff = a - b;
      in_valid = v;
      in_cond  = cond;
      in_a     = a;
      in_tag   = tag;
      if (cond == 3'd3) begin
         in_res = sum[15:0];
         in_co  = sum[16];
         in_z   = (sum[15:0] == 16'd0);
         in_ofl = (a[15] == b[15]) && (sum[15] != a[15]);
      end else begin
         in_res = diff;
         in_co  = (a >= b);
         in_z   = (diff == 16'd0);
         in_ofl = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      drv_set   = 16'd0;
      drv_taken = 1'b0;
      case (cond)
         3'd0: drv_set = (a == b) ? 16'd1 : 16'd0;
         3'd1: drv_set = ($signed(a) <  $signed(b)) ? 16'd1 : 16'd0;
         3'd2: drv_set = ($signed(a) <= $signed(b)) ? 16'd1 : 16'd0;
         3'd3: drv_set = (int'(a) + int'(b) > 65535) ? 16'd1 : 16'd0;
         3'd4: drv_taken = (a == 16'd0);
         3'd5: drv_taken = (a != 16'd0);
         3'd6: drv_taken = ($signed(a) < 0);
         default: drv_taken = ($signed(a) >= 0);
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: advances on each clock edge from the inputs seen at that edge
   always @(posedge clk) begin
      if (rst_n) begin
         m_sz   = q.size();
         m_push = in_valid && (m_sz < 2);
         m_pop  = (m_sz > 0) && out_ready;
         if (flush) begin
            q.delete();
         end else begin
            if (m_pop) begin
               if (q[0].is_br && q[0].taken && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
               void'(q.pop_front());
            end
            if (m_push) q.push_back('{drv_set, drv_taken, in_cond[2], in_tag});
         end
      end
   end

   always @(negedge rst_n) begin
      q.delete();
      mcnt = 16'd0;
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("m_taken_cnt", 32'(taken_cnt), 32'(mcnt));
         if (q.size() != 0) begin
            chk("m_out_set", 32'(out_set), 32'(q[0].set));
            chk("m_out_taken", 32'(out_taken), 32'(q[0].taken));
            chk("m_out_is_br", 32'(out_is_br), 32'(q[0].is_br));
            chk("m_out_tag", 32'(out_tag), 32'(q[0].tag));
         end
      end
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
      chk("rst_out_set", 32'(out_set), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk_en = 1'b1;

      // Set conditions, consumer always ready
      out_ready = 1'b1;
      drive(1'b1, 3'd1, 16'h7FFF, 16'h8000, 4'd1); cyc();
      chk("slt_ofl_a", 32'(out_set), 32'h0000);
      chk("slt_valid", 32'(out_valid), 32'd1);
      drive(1'b1, 3'd1, 16'h8000, 16'h0001, 4'd2); cyc();
      chk("slt_ofl_b", 32'(out_set), 32'h0001);
      drive(1'b1, 3'd0, 16'd5, 16'd5, 4'd3); cyc();
      chk("seq_eq", 32'(out_set), 32'h0001);
      drive(1'b1, 3'd2, 16'd5, 16'd5, 4'd4); cyc();
      chk("sle_eq", 32'(out_set), 32'h0001);
      drive(1'b1, 3'd3, 16'hFFFF, 16'h0001, 4'd5); cyc();
      chk("sco_co", 32'(out_set), 32'h0001);
      drive(1'b1, 3'd2, 16'd5, 16'd2, 4'd6); cyc();
      chk("sle_gt", 32'(out_set), 32'h0000);

      // Branches
      drive(1'b1, 3'd4, 16'h0000, 16'd0, 4'd7); cyc();
      chk("beqz_taken", 32'(out_taken), 32'd1);
      chk("beqz_set", 32'(out_set), 32'd0);
      chk("beqz_is_br", 32'(out_is_br), 32'd1);
      drive(1'b1, 3'd5, 16'h0000, 16'd0, 4'd8); cyc();
      chk("bnez_taken", 32'(out_taken), 32'd0);
      drive(1'b1, 3'd6, 16'h8000, 16'd0, 4'd9); cyc();
      chk("bltz_taken", 32'(out_taken), 32'd1);
      drive(1'b1, 3'd7, 16'h8000, 16'd0, 4'd10); cyc();
      chk("bgez_taken", 32'(out_taken), 32'd0);
      drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0); cyc();
      chk("br_taken_cnt", 32'(taken_cnt), 32'd2);
      chk("br_drained", 32'(out_valid), 32'd0);

      // Backpressure
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 16'd1, 16'd1, 4'd1); cyc();
      chk("bp_ready1", 32'(in_ready), 32'd1);
      drive(1'b1, 3'd0, 16'd1, 16'd2, 4'd2); cyc();
      chk("bp_full", 32'(in_ready), 32'd0);
      drive(1'b1, 3'd0, 16'd3, 16'd3, 4'd3); cyc();
      chk("bp_blocked", 32'(in_ready), 32'd0);
      chk("bp_hold_tag", 32'(out_tag), 32'd1);
      out_ready = 1'b1; cyc();
      chk("bp_pop1_tag", 32'(out_tag), 32'd2);
      chk("bp_ready_after", 32'(in_ready), 32'd1);
      cyc();
      chk("bp_pop2_tag", 32'(out_tag), 32'd3);
      drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0); cyc();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Flush with a taken branch at the head
      out_ready = 1'b0;
      drive(1'b1, 3'd4, 16'd0, 16'd0, 4'd5); cyc();
      drive(1'b1, 3'd0, 16'd1, 16'd1, 4'd6); cyc();
      chk("fl_full", 32'(in_ready), 32'd0);
      drive(1'b1, 3'd0, 16'd2, 16'd2, 4'd7);
      out_ready = 1'b1; flush = 1'b1; cyc();
      flush = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_ready", 32'(in_ready), 32'd1);
      chk("fl_taken_cnt", 32'(taken_cnt), 32'd2);
      drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0); cyc();
      chk("fl_dropped", 32'(out_valid), 32'd0);

      // Asynchronous reset with two entries queued
      out_ready = 1'b0;
      drive(1'b1, 3'd6, 16'hFFFF, 16'd0, 4'd1); cyc();
      drive(1'b1, 3'd5, 16'h0001, 16'd0, 4'd2); cyc();
      drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_ready", 32'(in_ready), 32'd1);
      chk("ar_taken_cnt", 32'(taken_cnt), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] a, b;
         case ($urandom_range(0, 4))
            0: a = 16'h0000;
            1: a = 16'h8000;
            2: a = 16'h7FFF;
            default: a = 16'($urandom);
         endcase
         b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, 4'($urandom));
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("end_drained", 32'(out_valid), 32'd0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/alu_cond_resolve.md
Name: alu_cond_resolve

Overview:
Consumer end of the ALU result/flag interface. It takes a subtract or add result with its Z/Ofl/CO flags, plus operand A, from the execute stage. It resolves set-condition instructions (SEQ/SLT/SLE/SCO) and zero-compare branches (BEQZ/BNEZ/BLTZ/BGEZ) into a 16-bit set value and a taken bit. Results pass through a 2-entry buffer with valid/ready handshakes on both sides, so the execute stage decouples from writeback and fetch redirect.

Parameters:
DEPTH, 2, buffer entries; only 2 is supported.
TAGW, 4, width of the opaque instruction tag carried with each entry.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; empties buffer this cycle
in_valid  input  1  request carries a valid ALU result
in_ready  output  1  buffer can accept (count < 2)
in_cond  input  3  000 SEQ, 001 SLT, 010 SLE, 011 SCO, 100 BEQZ, 101 BNEZ, 110 BLTZ, 111 BGEZ
in_res  input  16  ALU Out (A-B for SEQ/SLT/SLE, A+B for SCO)
in_z  input  1  ALU Z
in_ofl  input  1  ALU signed Ofl
in_co  input  1  ALU CO
in_a  input  16  operand A (branch compare source)
in_tag  input  TAGW  passthrough tag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_set  output  16  16'h0001 if set-condition true, else 16'h0000; always 0 for branches
out_taken  output  1  branch taken; always 0 for set ops
out_is_br  output  1  head is a branch (in_cond[2])
out_tag  output  TAGW  tag of head entry
taken_cnt  output  16  saturating count of taken branches popped

Behaviour:
- Reset (rst_n low, async): count=0, out_valid=0, out_set=0, out_taken=0, out_is_br=0, out_tag=0, taken_cnt=0, in_ready=1. Reset mid-transfer discards all entries.
- Resolution happens at push and is registered into the entry. Outputs come directly from head-entry flops with no combinational path from in_* to out_*.
  - SEQ = in_z
  - SLT = in_res[15] ^ in_ofl
  - SLE = SLT | in_z
  - SCO = in_co
  - BEQZ = (in_a==0)
  - BNEZ = (in_a!=0)
  - BLTZ = in_a[15]
  - BGEZ = ~in_a[15]
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count<2), from registered count only; it does not depend on out_ready. When full, a pop frees space next cycle.
- Latency: an entry pushed in cycle N into an empty buffer shows out_valid=1 in cycle N+1.
- Order is strict FIFO. Push and pop in the same cycle with count=1: head advances to the new entry, count stays 1.
- Head output is held stable while out_valid & ~out_ready.
- State: EMPTY (count 0) -> ONE on push. ONE -> TWO on push without pop. ONE -> EMPTY on pop without push. ONE stays ONE on push+pop. TWO -> ONE on pop.
- flush: next cycle count=0 and out_valid=0. Flush overrides a simultaneous push and pop; the pushed entry is dropped and taken_cnt does not increment for the popped entry.
- taken_cnt increments by 1 on each pop with out_is_br & out_taken. It saturates at 16'hFFFF and is cleared only by reset.
- in_* values are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-stream with 2 entries queued -> out_valid=0, in_ready=1, taken_cnt=0 immediately (asynchronous, before the next edge).
- SLT overflow: cond=001, A=16'h7FFF, B=16'h8000, res=16'hFFFF, ofl=1 -> out_set=16'h0000 at N+1. Then A=16'h8000, B=16'h0001, res=16'h7FFF, ofl=1 -> out_set=16'h0001.
- SEQ/SLE/SCO: res=0, z=1 for SEQ and SLE -> 16'h0001 each. SCO with co=1 -> 16'h0001. SLE with res=16'h0003, z=0, ofl=0 -> 16'h0000.
- Branches: BEQZ a=0 -> taken=1, set=0. BNEZ a=0 -> taken=0. BLTZ a=16'h8000 -> taken=1. BGEZ a=16'h8000 -> taken=0. Pop all -> taken_cnt=2.
- Backpressure: out_ready=0 and push 3 entries -> the third is blocked with in_ready=0 after the second. Raise out_ready -> tags pop in order; in_ready=1 the cycle after the first pop.
- Flush: count=2 with push+pop asserted together with flush, head is a taken branch -> next cycle out_valid=0, count=0, taken_cnt unchanged.
